// File: rtl/mult_booth_seq.sv
// Sequential 32-bit signed radix-2 Booth multiplier.
// Four carry-lookahead 8-bit slices form the per-cycle add/subtract path.

// 8-bit carry-lookahead slice with group generate/propagate
module eight_bit_adder (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_s,
    output logic       o_g0,
    output logic       o_p0
);
    logic [7:0] w_g;
    logic [7:0] w_p;
    logic [8:0] w_c;
    logic       w_gg;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Lookahead carries plus cin-independent group generate
    always_comb begin
        w_c    = '0;
        w_c[0] = i_cin;
        w_gg   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
            w_gg     = w_g[i] | (w_p[i] & w_gg);
        end
    end

    assign o_s  = w_p ^ w_c[7:0];
    assign o_g0 = w_gg;
    assign o_p0 = &w_p;
endmodule

module mult_booth_seq (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [31:0] r_m;
    logic [64:0] r_p;
    logic [5:0]  r_cnt;
    logic [31:0] r_result;
    logic        r_exc;
    logic        r_rdy;
    logic        r_busy;

    logic [31:0] w_hi;
    logic        w_add;
    logic        w_sub;
    logic [31:0] w_op;
    logic [31:0] w_sum;
    logic [4:0]  w_c;
    logic [3:0]  w_gk;
    logic [3:0]  w_pk;
    logic        w_sign;
    logic [64:0] w_pnext;
    logic        w_ovf;

    assign w_hi  = r_p[64:33];
    assign w_add = (r_p[1:0] == 2'b01);
    assign w_sub = (r_p[1:0] == 2'b10);
    assign w_op  = w_sub ? ~r_m : (w_add ? r_m : 32'd0);

    assign w_c[0] = w_sub;

    for (genvar k = 0; k < 4; k++) begin : g_slice
        eight_bit_adder u_add (
            .i_a   (w_hi[8*k +: 8]),
            .i_b   (w_op[8*k +: 8]),
            .i_cin (w_c[k]),
            .o_s   (w_sum[8*k +: 8]),
            .o_g0  (w_gk[k]),
            .o_p0  (w_pk[k])
        );
        assign w_c[k+1] = w_gk[k] | (w_pk[k] & w_c[k]);
    end

    // Shift in the sign of the exact 33-bit sum so hi - (-2^31) cannot wrap
    assign w_sign  = w_hi[31] ^ w_op[31] ^ w_c[4];
    assign w_pnext = {w_sign, w_sum, r_p[32:1]};
    assign w_ovf   = (w_pnext[64:33] != {32{w_pnext[32]}});

    // Control FSM, Booth datapath and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_m      <= '0;
            r_p      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            if (ctrl_MULT) begin
                r_state <= S_RUN;
                r_m     <= data_operandA;
                r_p     <= {32'd0, data_operandB, 1'b0};
                r_cnt   <= '0;
                r_busy  <= 1'b1;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        r_state <= S_IDLE;
                    end
                    S_RUN: begin
                        r_p   <= w_pnext;
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == 6'd31) begin
                            r_state  <= S_DONE;
                            r_busy   <= 1'b0;
                            r_rdy    <= 1'b1;
                            r_result <= w_pnext[32:1];
                            r_exc    <= w_ovf;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;
    assign busy           = r_busy;
endmodule

// File: tb/tb_mult_booth_seq.sv
// Testbench for mult_booth_seq: directed vectors plus a
// cycle-level reference model checked on every falling edge.
module tb_mult_booth_seq;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl  = 1'b0;
    logic [31:0] opa   = '0;
    logic [31:0] opb   = '0;
    logic [31:0] res;
    logic        exc;
    logic        rdy;
    logic        bsy;

    int tests = 0;
    int fails = 0;

    mult_booth_seq dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl),
        .data_operandA  (opa),
        .data_operandB  (opb),
        .data_result    (res),
        .data_exception (exc),
        .data_resultRDY (rdy),
        .busy           (bsy)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] ref_lo(input logic [31:0] x, input logic [31:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return p[31:0];
    endfunction

    function automatic logic ref_ovf(input logic [31:0] x, input logic [31:0] y);
        longint p;
        longint q;
        p = longint'($signed(x)) * longint'($signed(y));
        q = longint'($signed(p[31:0]));
        return p != q;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: a start is answered 32 edges later unless restarted
    logic        m_rdy  = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_exc  = 1'b0;
    logic [31:0] m_res  = '0;
    logic        m_pend = 1'b0;
    int          m_left = 0;
    logic [31:0] m_a    = '0;
    logic [31:0] m_b    = '0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_rdy  <= 1'b0;
            m_busy <= 1'b0;
            m_exc  <= 1'b0;
            m_res  <= '0;
            m_pend <= 1'b0;
            m_left <= 0;
        end else if (ctrl) begin
            m_pend <= 1'b1;
            m_left <= 32;
            m_a    <= opa;
            m_b    <= opb;
            m_rdy  <= 1'b0;
            m_busy <= 1'b1;
        end else if (m_pend && m_left == 1) begin
            m_pend <= 1'b0;
            m_left <= 0;
            m_rdy  <= 1'b1;
            m_busy <= 1'b0;
            m_res  <= ref_lo(m_a, m_b);
            m_exc  <= ref_ovf(m_a, m_b);
        end else begin
            m_rdy <= 1'b0;
            if (m_pend) m_left <= m_left - 1;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clock) begin
        chk("cyc_rdy", {31'd0, rdy}, {31'd0, m_rdy});
        chk("cyc_busy", {31'd0, bsy}, {31'd0, m_busy});
        chk("cyc_result", res, m_res);
        chk("cyc_exc", {31'd0, exc}, {31'd0, m_exc});
    end

    task automatic start(input logic [31:0] x, input logic [31:0] y);
        ctrl = 1'b1;
        opa  = x;
        opb  = y;
        @(negedge clock);
        ctrl = 1'b0;
        opa  = $urandom;
        opb  = $urandom;
    endtask

    task automatic wait_rdy(output int lat);
        lat = 1;
        while (!rdy && lat < 40) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic op(input string nm, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] er, input logic ee);
        int lat;
        start(x, y);
        wait_rdy(lat);
        chk({nm, "_lat"}, lat, 32'd33);
        chk({nm, "_res"}, res, er);
        chk({nm, "_exc"}, {31'd0, exc}, {31'd0, ee});
        @(negedge clock);
        chk({nm, "_rdy_off"}, {31'd0, rdy}, 32'd0);
        chk({nm, "_busy_off"}, {31'd0, bsy}, 32'd0);
    endtask

    initial begin
        int lat;
        logic [31:0] x;
        logic [31:0] y;

        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_res", res, 32'd0);
        chk("rst_exc", {31'd0, exc}, 32'd0);
        chk("rst_rdy", {31'd0, rdy}, 32'd0);
        chk("rst_busy", {31'd0, bsy}, 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // Model pinned by literals
        chk("model_lo", ref_lo(32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
        chk("model_ovf", {31'd0, ref_ovf(32'h8000_0000, 32'hFFFF_FFFF)}, 32'd1);

        op("basic", 32'd3, 32'd5, 32'h0000_000F, 1'b0);
        op("neg7x6", -32'sd7, 32'd6, 32'hFFFF_FFD6, 1'b0);
        op("m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        op("zero", 32'd0, 32'h7FFF_FFFF, 32'h0, 1'b0);
        op("ovf16", 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1);
        op("minxm1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        op("minx1", 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0);

        // Restart at edge 10
        start(32'd3, 32'd5);
        repeat (9) @(negedge clock);
        start(32'd7, 32'd9);
        wait_rdy(lat);
        chk("restart_lat", lat, 32'd33);
        chk("restart_res", res, 32'h0000_003F);
        @(negedge clock);

        // Reset mid-operation
        start(32'd100, 32'd100);
        repeat (14) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("midrst_res", res, 32'd0);
        chk("midrst_rdy", {31'd0, rdy}, 32'd0);
        chk("midrst_busy", {31'd0, bsy}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        op("after_rst", 32'd2, 32'd2, 32'h4, 1'b0);

        // Start in DONE
        start(32'd9, 32'd9);
        wait_rdy(lat);
        chk("done_first_res", res, 32'h51);
        chk("done_first_rdy", {31'd0, rdy}, 32'd1);
        start(32'd4, 32'd4);
        wait_rdy(lat);
        chk("done_second_lat", lat, 32'd33);
        chk("done_second_res", res, 32'h10);
        @(negedge clock);

        // Held strobe: last sampled operands win
        ctrl = 1'b1;
        opa = 32'd5;  opb = 32'd5;  @(negedge clock);
        opa = 32'd6;  opb = 32'd6;  @(negedge clock);
        opa = 32'd11; opb = 32'd13; @(negedge clock);
        ctrl = 1'b0;
        wait_rdy(lat);
        chk("held_lat", lat, 32'd33);
        chk("held_res", res, 32'h8F);
        @(negedge clock);

        // Random signed sweep, restarted in each DONE cycle
        for (int i = 0; i < 1000; i++) begin
            x = $urandom;
            y = $urandom;
            if (i % 2 == 0) begin
                x = {{16{x[15]}}, x[15:0]};
                y = {{16{y[15]}}, y[15:0]};
            end
            if (i % 97 == 0) x = 32'h8000_0000;
            start(x, y);
            wait_rdy(lat);
            chk("rand_lat", lat, 32'd33);
            chk("rand_res", res, ref_lo(x, y));
        end

        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
